rf_dump_reader: RTL and testbench

- Debug/trace initiator that reads a contiguous, wrapping range of general-purpose registers through the register file's asynchronous read port.
- Each word is streamed out on a valid/ready interface tagged with its register index.
- Sits beside the core and drives a dedicated read-address port (a third read port, or a muxed rs2 when the core is halted); it never writes the register file.
- Used for halt-time state dumps and post-run checking.

---
 rtl/rf_dump_pkg.sv | 23 ++
 rtl/rf_dump_reader_if.sv | 35 +++
 rtl/rf_dump_reader.sv | 108 ++++++++++
 tb/tb_rf_dump_reader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_dump_pkg.sv
// Shared types for the register-file dump reader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_dump_pkg;

  localparam int RF_DUMP_DATA_W = 32;
  localparam int RF_DUMP_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } rf_dump_state_e;

  // Output register bundle: one streamed register word.
  typedef struct packed {
    logic [RF_DUMP_DATA_W-1:0] data;
    logic [RF_DUMP_ADDR_W-1:0] addr;
    logic                      last;
  } rf_dump_word_t;

endpackage

// File: rtl/rf_dump_reader_if.sv
// Control, register-file read port and output stream of the dump reader.
// Latency: n/a (wiring only).
// Backpressure: carried by out_valid/out_ready.
interface rf_dump_reader_if
  import rf_dump_pkg::*;
#(
  parameter int DATA_W = RF_DUMP_DATA_W,
  parameter int ADDR_W = RF_DUMP_ADDR_W
);
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              abort;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;

  // Dump reader side.
  modport master (
    input  start, first_addr, last_addr, abort, rf_rdata, out_ready,
    output rf_raddr, out_valid, out_data, out_addr, out_last, busy, done
  );

  // Environment side: controller, register file and stream sink.
  modport slave (
    output start, first_addr, last_addr, abort, rf_rdata, out_ready,
    input  rf_raddr, out_valid, out_data, out_addr, out_last, busy, done
  );
endinterface

// File: rtl/rf_dump_reader.sv
// Streams a wrapping range of registers, read via the async RF port, tagged with index.
// Latency: start in cycle N -> first out_valid in N+2; one word per 2 cycles max.
// Backpressure: word held stable while out_valid && !out_ready; abort drops it.
module rf_dump_reader
  import rf_dump_pkg::*;
#(
  parameter int DATA_W        = RF_DUMP_DATA_W,
  parameter int ADDR_W        = RF_DUMP_ADDR_W,
  parameter bit FORCE_X0_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  rf_dump_reader_if.master bus
);

  rf_dump_state_e    state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  rf_dump_word_t     word_q, word_d;
  logic              vld_q, vld_d;
  logic              done_q, done_d;
  logic              hs;
  logic [ADDR_W-1:0] cur_inc;

  assign hs      = vld_q && bus.out_ready;
  // Index wraps naturally modulo 2**ADDR_W.
  assign cur_inc = cur_q + ADDR_W'(1);

  // Next-state decode; abort overrides every state and never yields a done pulse.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    end_d   = end_q;
    raddr_d = raddr_q;
    word_d  = word_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            cur_d   = bus.first_addr;
            end_d   = bus.last_addr;
            raddr_d = bus.first_addr;
            state_d = READ;
          end
        end
        READ: begin
          // x0 storage is not reset, so its read data is not trusted.
          word_d.data = (FORCE_X0_ZERO && cur_q == '0) ? '0 : bus.rf_rdata;
          word_d.addr = cur_q;
          word_d.last = (cur_q == end_q);
          vld_d       = 1'b1;
          state_d     = SEND;
        end
        SEND: begin
          if (hs) begin
            vld_d = 1'b0;
            if (word_q.last) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              cur_d   = cur_inc;
              raddr_d = cur_inc;
              state_d = READ;
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      end_q   <= '0;
      raddr_q <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      raddr_q <= raddr_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign bus.rf_raddr  = raddr_q;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = word_q.data;
  assign bus.out_addr  = word_q.addr;
  assign bus.out_last  = word_q.last;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rf_dump_reader.sv
// Scoreboarded bench for rf_dump_reader: directed dumps, wrap, stall, abort, reset.
// Latency: checks first word two cycles after start.
// Backpressure: out_ready driven by the stimulus process.
module tb_rf_dump_reader;
  import rf_dump_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_dump_reader_if bus ();
  logic [31:0] regs [32];
  assign bus.rf_rdata = regs[bus.rf_raddr];

  rf_dump_reader #(
    .DATA_W(32), .ADDR_W(5), .FORCE_X0_ZERO(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  rf_dump_word_t exp_q[$];
  rf_dump_word_t mon_exp;

  logic [4:0]  wrap_addr [5] = '{5'd30, 5'd31, 5'd0, 5'd1, 5'd2};
  logic [31:0] wrap_data [5] = '{32'h1000_001E, 32'h1000_001F, 32'h0, 32'h1000_0001, 32'h1000_0002};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every accepted word; count done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) done_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got addr %0d data %0h, expected none", bus.out_addr, bus.out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("word_data", bus.out_data, mon_exp.data);
          chk("word_addr", bus.out_addr, mon_exp.addr);
          chk("word_last", bus.out_last, mon_exp.last);
        end
      end
    end
  end

  task automatic push_word(input logic [4:0] a, input logic last);
    rf_dump_word_t w;
    w.addr = a;
    w.data = (a == 5'd0) ? 32'h0 : regs[a];
    w.last = last;
    exp_q.push_back(w);
  endtask

  task automatic push_range(input logic [4:0] f, input logic [4:0] l);
    logic [4:0] a;
    logic [4:0] span;
    int n;
    a = f;
    span = l - f;
    n = int'(span) + 1;
    for (int i = 0; i < n; i++) begin
      push_word(a, i == n - 1);
      a = a + 5'd1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the following cycle.
  task automatic pulse_start(input logic [4:0] f, input logic [4:0] l);
    bus.first_addr = f;
    bus.last_addr  = l;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) seen = 1'b1;
    end
    chk({name, "_done_seen"}, seen, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int h0;
    int stable;
    bit hit;

    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    regs[0] = 32'hFFFF_FFFF;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.first_addr = '0;
    bus.last_addr = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    #12;
    chk("rst_raddr", bus.rf_raddr, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_addr", bus.out_addr, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full 0..31 dump with x0 forced to zero.
    d0 = done_cnt; h0 = hs_cnt;
    push_range(5'd0, 5'd31);
    pulse_start(5'd0, 5'd31);
    chk("lat_n1_valid", bus.out_valid, 0);
    chk("lat_n1_busy", bus.busy, 1);
    @(posedge clk); #1;
    chk("lat_n2_valid", bus.out_valid, 1);
    wait_done("full");
    repeat (3) @(posedge clk); #1;
    chk("full_words", hs_cnt - h0, 32);
    chk("full_done_once", done_cnt - d0, 1);
    chk("full_busy_after", bus.busy, 0);
    chk("full_q_empty", exp_q.size(), 0);

    // Wrapping range 30..2.
    h0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      rf_dump_word_t w;
      w.addr = wrap_addr[i];
      w.data = wrap_data[i];
      w.last = (i == 4);
      exp_q.push_back(w);
    end
    pulse_start(5'd30, 5'd2);
    wait_done("wrap");
    chk("wrap_words", hs_cnt - h0, 5);
    chk("wrap_q_empty", exp_q.size(), 0);

    // Backpressure: single word held for 7 stalled cycles.
    regs[5] = 32'hDEAD_BEEF;
    bus.out_ready = 1'b0;
    exp_q.push_back('{data: 32'hDEAD_BEEF, addr: 5'd5, last: 1'b1});
    d0 = done_cnt;
    pulse_start(5'd5, 5'd5);
    @(posedge clk); #1;
    stable = 0;
    for (int i = 0; i < 7; i++) begin
      if (bus.out_valid && bus.out_data == 32'hDEAD_BEEF && bus.out_addr == 5'd5 && bus.out_last)
        stable++;
      if (i < 6) begin
        @(posedge clk); #1;
      end
    end
    chk("bp_stable_cycles", stable, 7);
    @(posedge clk); #1;
    chk("bp_c8_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_done", bus.done, 1);
    chk("bp_valid_clear", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("bp_done_once", done_cnt - d0, 1);
    chk("bp_q_empty", exp_q.size(), 0);

    // Abort after three handshakes.
    d0 = done_cnt; h0 = hs_cnt;
    push_word(5'd0, 1'b0);
    push_word(5'd1, 1'b0);
    push_word(5'd2, 1'b0);
    pulse_start(5'd0, 5'd31);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      if (hs_cnt - h0 >= 3) hit = 1'b1;
    end
    chk("abort_reached3", hit, 1);
    bus.out_ready = 1'b0;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    repeat (5) @(posedge clk); #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_words", hs_cnt - h0, 3);
    chk("abort_q_empty", exp_q.size(), 0);
    bus.out_ready = 1'b1;
    push_range(5'd4, 5'd6);
    pulse_start(5'd4, 5'd6);
    wait_done("post_abort");
    chk("post_abort_q_empty", exp_q.size(), 0);

    // Abort and start together in IDLE: nothing starts.
    h0 = hs_cnt;
    bus.first_addr = 5'd7; bus.last_addr = 5'd7;
    bus.abort = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0; bus.start = 1'b0;
    chk("abst_busy", bus.busy, 0);
    @(posedge clk); #1;
    chk("abst_valid", bus.out_valid, 0);
    chk("abst_words", hs_cnt - h0, 0);

    // Start while busy is ignored.
    h0 = hs_cnt;
    push_range(5'd0, 5'd3);
    pulse_start(5'd0, 5'd3);
    bus.first_addr = 5'd10; bus.last_addr = 5'd12; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("busy_start");
    repeat (10) @(posedge clk); #1;
    chk("busy_start_words", hs_cnt - h0, 4);
    chk("busy_start_idle", bus.busy, 0);
    chk("busy_start_q_empty", exp_q.size(), 0);

    // Async reset mid-SEND.
    bus.out_ready = 1'b0;
    pulse_start(5'd0, 5'd31);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_raddr", bus.rf_raddr, 0);
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_data", bus.out_data, 0);
    chk("arst_addr", bus.out_addr, 0);
    chk("arst_last", bus.out_last, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_rel_busy", bus.busy, 0);
    chk("arst_rel_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    push_range(5'd31, 5'd31);
    pulse_start(5'd31, 5'd31);
    wait_done("recover");
    chk("recover_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
